// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
// AHB-Lite responder backed by a word-organised SRAM (2**SLAVE_ADDRWIDTH
// words). It supports byte, halfword and word transfers and inserts
// WAIT_STATES wait cycles per valid transfer. Illegal transfers (bad size,
// misalignment, out of range) get the two-cycle ERROR response and never
// touch memory.
//
// Ports
//   HCLK       bus clock, rising-edge active
//   HRESETn    asynchronous active-low reset
//   HSEL       slave select from the address decoder
//   HADDR      byte address (address phase)
//   HTRANS     IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     1 = write, 0 = read
//   HSIZE      0 byte, 1 halfword, 2 word, others illegal
//   HBURST     burst type, informational only
//   HWDATA     write data (data phase)
//   HREADY     bus-level ready; address phases accepted only when high
//   HREADYOUT  slave ready
//   HRESP      0 OKAY, 1 ERROR
//   HRDATA     read data, holds its value outside read data phases
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
    parameter int DATAWIDTH       = 32,
    parameter int ADDRWIDTH       = 32,
    parameter int SLAVE_ADDRWIDTH = 10,
    parameter int WAIT_STATES     = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [DATAWIDTH-1:0] HRDATA
);
    localparam int NLANES = DATAWIDTH / 8;
    localparam int DEPTH  = 2 ** SLAVE_ADDRWIDTH;
    localparam int AW     = SLAVE_ADDRWIDTH + 2;  // byte address bits inside the slave
    localparam bit HAS_WAIT = (WAIT_STATES > 0);

    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;
    localparam logic [2:0] SIZE_HALF    = 3'd1;
    localparam logic [2:0] SIZE_WORD    = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    state_t              w_capture_state;
    logic [3:0]          r_wait_cnt;
    logic [AW-1:0]       r_addr;
    logic                r_write;
    logic [1:0]          r_size;
    logic [DATAWIDTH-1:0] r_hrdata;

    logic                w_capture;
    logic                w_addr_err;
    logic                w_load;
    logic                w_wr_en;
    logic                w_rd_active;
    logic [NLANES-1:0]   w_be;
    logic [SLAVE_ADDRWIDTH-1:0] w_word;
    logic [DATAWIDTH-1:0] w_mem_rdata;
    logic                w_unused;

    assign w_unused = ^HBURST;

    assign w_capture = HSEL && HREADY && (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);

    assign w_addr_err = (HSIZE > SIZE_WORD)
                     || (HSIZE == SIZE_HALF && HADDR[0])
                     || (HSIZE == SIZE_WORD && HADDR[1:0] != 2'b00)
                     || (HADDR[ADDRWIDTH-1:AW] != '0);

    // Destination of an accepted address phase; identical from IDLE, DATA and ERR2.
    assign w_capture_state = w_addr_err ? ST_ERR1 : (HAS_WAIT ? ST_WAIT : ST_DATA);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        HREADYOUT    = 1'b1;
        HRESP        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                HRESP = (r_state == ST_ERR2);
                if (w_capture) begin
                    w_state_next = w_capture_state;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wait_cnt <= 4'd1) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_ERR1: begin
                HREADYOUT    = 1'b0;
                HRESP        = 1'b1;
                w_state_next = ST_ERR2;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_hrdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_addr     <= HADDR[AW-1:0];
                r_write    <= HWRITE;
                r_size     <= HSIZE[1:0];
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            // Remember the last read word so HRDATA holds it afterwards.
            if (w_rd_active) begin
                r_hrdata <= w_mem_rdata;
            end
        end
    end

    // Byte-lane enables, little-endian.
    always_comb begin
        w_be = '0;
        case (r_size)
            2'd0:    w_be[r_addr[1:0]] = 1'b1;
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_word      = r_addr[AW-1:2];
    assign w_wr_en     = (r_state == ST_DATA) && r_write;
    assign w_rd_active = (r_state == ST_DATA) && !r_write;

    // One byte-wide array per lane. The read is combinational from the
    // registered address, so a write committed on the edge that captures a
    // read of the same word is already visible in the read data phase.
    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            always_ff @(posedge HCLK) begin
                if (w_wr_en && w_be[gi]) begin
                    r_mem[w_word] <= HWDATA[8*gi +: 8];
                end
            end
            assign w_mem_rdata[8*gi +: 8] = r_mem[w_word];
        end
    endgenerate

    assign HRDATA = w_rd_active ? w_mem_rdata : r_hrdata;

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: a word-organised SRAM slave that answers transfers from the bus master and the address decoder.
- Decodes address and data phases and inserts a configurable number of wait states.
- Performs byte, halfword and word reads and writes.
- Returns the two-cycle ERROR response for illegal transfers.
- Serves as the DUT-side memory for the master/bus verification environment.

Parameters:
- DATAWIDTH, 32, HWDATA/HRDATA width (only 32 supported).
- ADDRWIDTH, 32, HADDR width.
- SLAVE_ADDRWIDTH, 10, word-index bits; depth is 2**10 = 1024 words (4 KB).
- WAIT_STATES, 0, wait cycles inserted per valid transfer (range 0..15).

Ports:
- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  READ=0, WRITE=1.
- HSIZE  in  3  BYTE=0, HALFWORD=1, WORD=2; 3..7 are illegal.
- HBURST  in  3  burst type; informational only, no internal address generation.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is accepted only when HREADY=1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  OKAY=0, ERROR=1.
- HRDATA  out  32  read data.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, FSM=IDLE, wait counter=0.
  - Memory array is not reset.
  - Reset asserted mid-transfer abandons the transfer; a pending write is not committed.
- Address-phase capture:
  - Condition: rising edge with HSEL=1, HREADY=1 and HTRANS in {NONSEQ, SEQ}.
  - Registered: HADDR, HWRITE, HSIZE.
  - Otherwise, including IDLE, BUSY or HSEL=0, no transfer is captured and the next data phase is a zero-wait OKAY.
- Error check, evaluated at capture. Any of the following is an error:
  - HSIZE > WORD.
  - HSIZE=HALFWORD with HADDR[0]=1.
  - HSIZE=WORD with HADDR[1:0]!=0.
  - HADDR[31:12] != 0, i.e. out of the 4 KB range.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - On a capture with an error, go to ERR1.
    - On a capture with WAIT_STATES>0, go to WAIT and load the counter with WAIT_STATES.
    - On a capture with WAIT_STATES=0, go to DATA.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Decrement the counter each cycle; when the counter reaches 1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY.
    - Write: HWDATA is sampled on this edge and byte-enabled lanes are committed.
    - Read: HRDATA drives the addressed word.
    - Pipelining: a new capture on the same edge follows the same rules as in IDLE; with no capture, go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Captures are allowed on this edge, with the same rules as IDLE. No memory access occurs for the errored transfer.
- Byte lanes (little-endian):
  - BYTE: lane = HADDR[1:0].
  - HALFWORD: lanes {1:0} if HADDR[1]=0, {3:2} if HADDR[1]=1.
  - WORD: all four lanes.
  - Unwritten lanes are preserved.
  - Reads return the full word on HRDATA regardless of size.
- Read-after-write: a read captured on the same edge that commits a write to the same word must return the updated word.
  - Either a forward or a combinational read from the registered address is acceptable.
- HRDATA holds its last value outside read DATA cycles. It must not glitch to X when HREADYOUT=1.
- A BUSY transfer inside a burst gets a zero-wait OKAY and never accesses memory.

Test Plan:
- Reset, then single WORD write of 0xDEADBEEF to 0x010, then a read of 0x010 with WAIT_STATES=0 -> both data phases complete in 1 cycle with OKAY; HRDATA=0xDEADBEEF.
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x020..0x023, then a WORD read of 0x020 -> HRDATA=0x44332211. HALFWORD write 0xABCD to 0x022 -> next read gives 0xABCD2211.
- WAIT_STATES=2, INCR4 write then read at 0x100 -> each beat shows HREADYOUT low for exactly 2 cycles then high; read data matches written data.
- WORD read at 0x002 (misaligned), HSIZE=3, and HADDR=0x1000 -> each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; memory is unchanged afterwards.
- Back-to-back pipelined write 0x0 -> 0x5A5A5A5A followed immediately by a read of 0x0 -> the read returns 0x5A5A5A5A with no extra wait.
- HRESETn asserted during the WAIT state of a write to 0x040 (previously 0x12345678) -> outputs return to reset values immediately; a later read returns 0x12345678.
